mem_io_responder: RTL and testbench

MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

---
 rtl/mem_io_responder_pkg.sv | 28 ++
 rtl/mem_io_responder_ram.sv | 34 +++
 rtl/mem_io_responder.sv | 183 ++++++++++++++++++
 tb/tb_mem_io_responder.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/mem_io_responder_pkg.sv
// Shared processor package for the memory/I-O responder.
// Holds the responder FSM state encoding, the I/O register offsets inside
// the I/O window, and the latched request record used by the top level.
package mem_io_responder_pkg;

    localparam int DATA_W = 32;

    // Responder FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Byte offsets of the I/O registers relative to IO_BASE.
    localparam logic [31:0] IO_PORTOUT_OFF = 32'd0;  // PortOut, read/write
    localparam logic [31:0] IO_PORTIN_OFF  = 32'd4;  // PortIn, read-only
    localparam logic [31:0] IO_COUNT_OFF   = 32'd8;  // access counter, read-only

    // One processor request as captured in IDLE.
    typedef struct packed {
        logic              rd;
        logic              wr;
        logic [31:0]       addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/mem_io_responder_ram.sv
// responder_ram: word-addressed data RAM for the responder.
// Synchronous write, combinational (asynchronous) read, DEPTH words.
// Ports:
//   clk   - write clock
//   we    - write enable, commits wdata at the rising edge
//   addr  - word index for both read and write
//   wdata - write data
//   rdata - combinational read data for addr
module responder_ram
    import mem_io_responder_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the array has no reset; clearing it would force a flop-based
    // implementation instead of a RAM macro, and contents must survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_io_responder.sv
// mem_io_responder: memory and I/O slave for a simple processor bus.
// Decodes a RAM region and a three-register I/O window, inserts WAIT_STATES
// wait cycles, and answers each request with a one-cycle Ready pulse
// (Error qualifies Ready when the request was rejected).
// Ports:
//   clk, reset          - clock; asynchronous active-high reset
//   MemRead, MemWrite   - request strobes, held until Ready
//   Address, WriteData  - byte address and store data, held with the request
//   PortIn              - asynchronous 8-bit input pins (synchronized here)
//   ReadData            - registered read data, 0 whenever Ready=0
//   Ready, Error        - completion pulse and its reject flag
//   PortOut             - output port register
module mem_io_responder
    import mem_io_responder_pkg::*;
#(
    parameter int          MEMORY_DEPTH = 1024,
    parameter logic [31:0] RAM_BASE     = 32'h1001_0000,
    parameter logic [31:0] IO_BASE      = 32'h1001_1000,
    parameter int          WAIT_STATES  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic [7:0]  PortIn,
    output logic [31:0] ReadData,
    output logic        Ready,
    output logic        Error,
    output logic [31:0] PortOut
);

    localparam int          AW        = $clog2(MEMORY_DEPTH);
    localparam logic [31:0] RAM_BYTES = 32'(4 * MEMORY_DEPTH);

    state_t      state, next_state;
    req_t        req_q, req_cur;
    logic [3:0]  wait_cnt;
    logic [31:0] port_out_q;
    logic [31:0] access_cnt;
    logic [7:0]  sync_ff1, sync_ff2;
    logic [31:0] rdata_q, rdata_nxt;
    logic        err_q;

    logic [31:0] ram_off;
    logic        hit_ram, hit_out, hit_in, hit_cnt;
    logic        req_err, enter_resp;
    logic        ram_we;
    logic [31:0] ram_rdata;

    // The request being serviced: live bus inputs while IDLE (so a
    // zero-wait access can complete on its sampling edge), otherwise the
    // copy latched when the request was accepted.
    // NOTE: every signal written in an always_comb gets a default first so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        req_cur = req_q;
        if (state == IDLE) begin
            req_cur.rd    = MemRead;
            req_cur.wr    = MemWrite;
            req_cur.addr  = Address;
            req_cur.wdata = WriteData;
        end
    end

    // Address decode. The lower-bound test keeps the subtraction from
    // wrapping addresses below RAM_BASE into the RAM range.
    assign ram_off = req_cur.addr - RAM_BASE;
    assign hit_ram = (req_cur.addr >= RAM_BASE) && (ram_off < RAM_BYTES);
    assign hit_out = (req_cur.addr == IO_BASE + IO_PORTOUT_OFF);
    assign hit_in  = (req_cur.addr == IO_BASE + IO_PORTIN_OFF);
    assign hit_cnt = (req_cur.addr == IO_BASE + IO_COUNT_OFF);

    assign req_err = (req_cur.rd && req_cur.wr)
                   || (req_cur.addr[1:0] != 2'b00)
                   || !(hit_ram || hit_out || hit_in || hit_cnt)
                   || (req_cur.wr && (hit_in || hit_cnt));

    // FSM next state.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (MemRead || MemWrite) begin
                    next_state = (WAIT_STATES > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (wait_cnt == 4'd0) begin
                    next_state = RESP;
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // RESP always returns to IDLE, so a RESP next state marks the entry edge.
    assign enter_resp = (next_state == RESP);

    // Gating with reset keeps an access caught by reset from writing RAM.
    assign ram_we = enter_resp && !reset && req_cur.wr && !req_err && hit_ram;

    responder_ram #(
        .DEPTH (MEMORY_DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_off[AW+1:2]),
        .wdata (req_cur.wdata),
        .rdata (ram_rdata)
    );

    // Read mux. PortOut is read from its current register, so a read sees
    // the value before any write in the same cycle.
    always_comb begin
        rdata_nxt = '0;
        if (req_cur.rd && !req_err) begin
            if (hit_ram) begin
                rdata_nxt = ram_rdata;
            end else if (hit_out) begin
                rdata_nxt = port_out_q;
            end else if (hit_in) begin
                rdata_nxt = {24'h0, sync_ff2};
            end else if (hit_cnt) begin
                rdata_nxt = access_cnt;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            req_q      <= '0;
            wait_cnt   <= '0;
            port_out_q <= '0;
            access_cnt <= '0;
            sync_ff1   <= '0;
            sync_ff2   <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state    <= next_state;
            sync_ff1 <= PortIn;
            sync_ff2 <= sync_ff1;

            if (state == IDLE && (MemRead || MemWrite)) begin
                req_q <= req_cur;
            end

            if (state == IDLE && next_state == WAIT) begin
                wait_cnt <= 4'(WAIT_STATES - 1);
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt - 4'd1;
            end

            if (enter_resp && req_cur.wr && !req_err && hit_out) begin
                port_out_q <= req_cur.wdata;
            end

            // Counted on the RESP cycle, after a counter read has been
            // captured on the edge entering RESP.
            if (state == RESP) begin
                access_cnt <= access_cnt + 32'd1;
            end

            // Loaded only on RESP entry and cleared otherwise, so both
            // outputs are zero whenever Ready is low.
            rdata_q <= enter_resp ? rdata_nxt : '0;
            err_q   <= enter_resp && req_err;
        end
    end

    assign Ready    = (state == RESP);
    assign ReadData = rdata_q;
    assign Error    = err_q;
    assign PortOut  = port_out_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed self-checking bench for mem_io_responder (default parameters,
// WAIT_STATES=1). Expected values are hand-computed constants.
module tb_mem_io_responder;

    localparam logic [31:0] IO_BASE = 32'h1001_1000;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite;
    logic [31:0] Address, WriteData;
    logic [7:0]  PortIn;
    logic [31:0] ReadData;
    logic        Ready, Error;
    logic [31:0] PortOut;

    int checks   = 0;
    int failures = 0;

    mem_io_responder dut (
        .clk       (clk),
        .reset     (reset),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Address   (Address),
        .WriteData (WriteData),
        .PortIn    (PortIn),
        .ReadData  (ReadData),
        .Ready     (Ready),
        .Error     (Error),
        .PortOut   (PortOut)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete request. Called #1 after a rising edge with the DUT idle.
    // Checks latency (2 edges for WAIT_STATES=1), Error, ReadData, and that
    // Ready is a single-cycle pulse with ReadData/Error back at 0 afterwards.
    task automatic xact(input string tag, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic exp_err, input logic [31:0] exp_rdata);
        int lat;
        MemRead   = rd;
        MemWrite  = wr;
        Address   = addr;
        WriteData = wdata;
        lat = 0;
        while (lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (Ready === 1'b1) break;
        end
        check({tag, ".latency"}, 32'(lat), 32'd2);
        check({tag, ".error"}, {31'b0, Error}, {31'b0, exp_err});
        check({tag, ".rdata"}, ReadData, exp_rdata);
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        @(posedge clk);
        #1;
        check({tag, ".ready_low"}, {31'b0, Ready}, 32'd0);
        check({tag, ".rdata_low"}, ReadData, 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        Address   = '0;
        WriteData = '0;
        PortIn    = 8'h00;
        #1;
        check("reset.ready", {31'b0, Ready}, 32'd0);
        check("reset.error", {31'b0, Error}, 32'd0);
        check("reset.rdata", ReadData, 32'd0);
        check("reset.portout", PortOut, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // RAM write then read-back.
        xact("ram_wr", 1'b0, 1'b1, 32'h1001_0010, 32'hDEAD_BEEF, 1'b0, 32'h0);
        xact("ram_rd", 1'b1, 1'b0, 32'h1001_0010, 32'h0, 1'b0, 32'hDEAD_BEEF);
        xact("ram0_wr", 1'b0, 1'b1, 32'h1001_0000, 32'h1111_1111, 1'b0, 32'h0);
        xact("ram_last_wr", 1'b0, 1'b1, 32'h1001_0FFC, 32'h7777_0FFC, 1'b0, 32'h0);
        xact("ram_last_rd", 1'b1, 1'b0, 32'h1001_0FFC, 32'h0, 1'b0, 32'h7777_0FFC);

        // PortOut write then read.
        xact("pout_wr", 1'b0, 1'b1, IO_BASE, 32'h0000_00A5, 1'b0, 32'h0);
        check("pout.value", PortOut, 32'h0000_00A5);
        xact("pout_rd", 1'b1, 1'b0, IO_BASE, 32'h0, 1'b0, 32'h0000_00A5);

        // PortIn through the synchronizer.
        PortIn = 8'h3C;
        repeat (3) @(posedge clk);
        #1;
        xact("pin_rd", 1'b1, 1'b0, IO_BASE + 32'd4, 32'h0, 1'b0, 32'h0000_003C);

        // Rejected requests leave RAM and PortOut alone.
        xact("err_misalign_rd", 1'b1, 1'b0, 32'h1001_0002, 32'h0, 1'b1, 32'h0);
        xact("err_misalign_wr", 1'b0, 1'b1, 32'h1001_0002, 32'h0000_0BAD, 1'b1, 32'h0);
        xact("err_unmapped", 1'b1, 1'b0, 32'h0000_0000, 32'h0, 1'b1, 32'h0);
        xact("err_past_ram", 1'b1, 1'b0, 32'h1001_1010, 32'h0, 1'b1, 32'h0);
        xact("err_rdwr", 1'b1, 1'b1, 32'h1001_0010, 32'h1234_5678, 1'b1, 32'h0);
        xact("err_rdwr_io", 1'b1, 1'b1, IO_BASE, 32'h0000_0077, 1'b1, 32'h0);
        xact("err_wr_pin", 1'b0, 1'b1, IO_BASE + 32'd4, 32'h0000_00FF, 1'b1, 32'h0);
        xact("err_wr_cnt", 1'b0, 1'b1, IO_BASE + 32'd8, 32'h0000_0099, 1'b1, 32'h0);
        check("err.portout", PortOut, 32'h0000_00A5);
        xact("err.ram10", 1'b1, 1'b0, 32'h1001_0010, 32'h0, 1'b0, 32'hDEAD_BEEF);
        xact("err.ram0", 1'b1, 1'b0, 32'h1001_0000, 32'h0, 1'b0, 32'h1111_1111);

        // Reset during WAIT of a RAM write aborts it.
        MemWrite  = 1'b1;
        Address   = 32'h1001_0000;
        WriteData = 32'h5555_5555;
        @(posedge clk);
        #1;
        check("abort.in_wait", {31'b0, Ready}, 32'd0);
        reset    = 1'b1;
        MemWrite = 1'b0;
        #1;
        check("abort.portout", PortOut, 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check("abort.no_ready", {31'b0, Ready}, 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Counter: cleared by reset, counts every completed access.
        xact("cnt_first", 1'b1, 1'b0, IO_BASE + 32'd8, 32'h0, 1'b0, 32'd0);
        xact("abort.ram_kept", 1'b1, 1'b0, 32'h1001_0000, 32'h0, 1'b0, 32'h1111_1111);
        xact("abort.pout_rd", 1'b1, 1'b0, IO_BASE, 32'h0, 1'b0, 32'h0);
        xact("ram4_wr", 1'b0, 1'b1, 32'h1001_0004, 32'hCAFE_0001, 1'b0, 32'h0);
        xact("ram4_rd", 1'b1, 1'b0, 32'h1001_0004, 32'h0, 1'b0, 32'hCAFE_0001);
        xact("cnt_five", 1'b1, 1'b0, IO_BASE + 32'd8, 32'h0, 1'b0, 32'd5);
        xact("cnt_err_step", 1'b1, 1'b0, 32'h0000_0000, 32'h0, 1'b1, 32'h0);
        xact("cnt_seven", 1'b1, 1'b0, IO_BASE + 32'd8, 32'h0, 1'b0, 32'd7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
